// File: rtl/pe_job_sequencer.sv
// Job sequencer for one multiply-accumulate PE. It streams operand pairs, pulses format, and queues results in order.
// Optional perf counters are enabled with `define PE_JOB_SEQ_PERF_CNT_EN.
module pe_job_sequencer #(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_LEN  = 8,
    parameter int PE_LAT     = 2,
    parameter int RES_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [WIDTH_LEN-1:0]  cmd_len_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [WIDTH_DATA-1:0] op_a_i,
    input  logic [WIDTH_DATA-1:0] op_b_i,
    output logic [WIDTH_DATA-1:0] pe_data_a_o,
    output logic [WIDTH_DATA-1:0] pe_data_b_o,
    output logic                  pe_format_en_o,
    output logic                  pe_keep_data_o,
    input  logic [WIDTH_DATA-1:0] pe_data_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [WIDTH_DATA-1:0] res_data_o,
    output logic                  busy_o
`ifdef PE_JOB_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_jobs_o,
    output logic [31:0]           perf_stall_o
`endif
);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int OUT_W = $clog2(RES_DEPTH + 1);
    localparam logic [OUT_W-1:0] DEPTH_CNT = OUT_W'(RES_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FMT = 2'd2} state_t;

    state_t               state, state_next;
    logic [WIDTH_LEN-1:0] rem, rem_next;
    logic [OUT_W-1:0]     outst;
    logic [OUT_W-1:0]     count;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [WIDTH_DATA-1:0] mem [RES_DEPTH];
    logic [PE_LAT-1:0]    fmt_sr;
    logic                 credit_ok, cmd_fire, op_fire, res_fire, wr_en;

    // Every handshake transfers exactly on a cycle where valid and ready are both high;
    // valid never depends on ready, and ready only depends on state and credits.
    assign credit_ok      = (outst < DEPTH_CNT);
    assign cmd_fire       = cmd_valid_i & cmd_ready_o;
    assign op_fire        = op_valid_i & op_ready_o;
    assign res_fire       = res_valid_o & res_ready_i;
    assign wr_en          = fmt_sr[PE_LAT-1];
    assign pe_keep_data_o = 1'b0;
    assign busy_o         = (outst != '0);
    assign res_valid_o    = (count != '0);
    assign res_data_o     = res_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    always_comb begin
        state_next     = state;
        rem_next       = rem;
        cmd_ready_o    = 1'b0;
        op_ready_o     = 1'b0;
        pe_format_en_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = credit_ok;
                if (cmd_valid_i && credit_ok) begin
                    rem_next   = cmd_len_i;
                    state_next = (cmd_len_i == '0) ? FMT : STREAM;
                end
            end
            STREAM: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    rem_next = rem - 1'b1;
                    if (rem == WIDTH_LEN'(1)) state_next = FMT;
                end
            end
            FMT: begin
                pe_format_en_o = 1'b1;
                cmd_ready_o    = credit_ok;
                if (cmd_valid_i && credit_ok) begin
                    rem_next   = cmd_len_i;
                    state_next = (cmd_len_i == '0) ? FMT : STREAM;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands live on the PE bus for exactly one cycle so stalls feed zeros into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_data_a_o <= '0;
            pe_data_b_o <= '0;
        end else begin
            pe_data_a_o <= op_fire ? op_a_i : '0;
            pe_data_b_o <= op_fire ? op_b_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= '0;
        end else begin
            case ({cmd_fire, res_fire})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_sr <= '0;
        end else begin
            fmt_sr <= (fmt_sr << 1) | PE_LAT'(pe_format_en_o);
        end
    end

    // Result FIFO; the credit counter guarantees a free slot whenever wr_en rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
            if (res_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, res_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pe_data_i;
    end

`ifdef PE_JOB_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs_o  <= '0;
            perf_stall_o <= '0;
        end else begin
            if (res_fire) perf_jobs_o <= perf_jobs_o + 32'd1;
            if (state == STREAM && !op_valid_i) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_job_sequencer.sv
// Bench for pe_job_sequencer with a behavioural Q6.9 MAC PE (PE_LAT=2) attached.
// Table-driven job vectors plus hand-written timing, stall, backpressure and reset sequences.
module tb_pe_job_sequencer;
    localparam int WD = 16;
    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [WL-1:0] cmd_len;
    logic          op_valid, op_ready;
    logic [WD-1:0] op_a, op_b;
    logic [WD-1:0] pe_data_a, pe_data_b, pe_data;
    logic          pe_format_en, pe_keep_data;
    logic          res_valid, res_ready;
    logic [WD-1:0] res_data;
    logic          busy;
`ifdef PE_JOB_SEQ_PERF_CNT_EN
    logic [31:0]   perf_jobs, perf_stall;
`endif

    int tests = 0;
    int fails = 0;
    logic [WD-1:0] exp_q[$];

    pe_job_sequencer #(.WIDTH_DATA(WD), .WIDTH_LEN(WL), .PE_LAT(2), .RES_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
        .pe_data_a_o(pe_data_a), .pe_data_b_o(pe_data_b),
        .pe_format_en_o(pe_format_en), .pe_keep_data_o(pe_keep_data),
        .pe_data_i(pe_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .busy_o(busy)
`ifdef PE_JOB_SEQ_PERF_CNT_EN
        , .perf_jobs_o(perf_jobs), .perf_stall_o(perf_stall)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural PE ----------------
    logic signed [31:0] acc, acc_sum;
    logic [WD-1:0]      pe_st1, pe_st2;
    assign acc_sum = acc + $signed(pe_data_a) * $signed(pe_data_b);
    assign pe_data = pe_st2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            pe_st1 <= '0;
            pe_st2 <= '0;
        end else begin
            pe_st2 <= pe_st1;
            if (pe_format_en) begin
                pe_st1 <= acc_sum[24:9];
                acc    <= '0;
            end else begin
                acc <= acc_sum;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Scoreboard: every fired result must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_unexpected: got %0h expected no result", res_data);
            end else begin
                check("res_data", {16'h0, res_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks (entered just after a rising edge) ----------------
    task automatic send_cmd(input int len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_len   = WL'(len);
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [WD-1:0] a, input logic [WD-1:0] b);
        int n = 0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("op_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int             len;
        logic [2:0][15:0] a;
        logic [2:0][15:0] b;
        logic [15:0]    exp_res;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input int len,
                           input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1,
                           input logic [15:0] a2, input logic [15:0] b2,
                           input logic [15:0] exp_res);
        vecs[i].len     = len;
        vecs[i].a       = {a2, a1, a0};
        vecs[i].b       = {b2, b1, b0};
        vecs[i].exp_res = exp_res;
    endtask

    initial begin
        // 1.0*1.0 + 1.0*1.0 = 2.0
        set_vec(0, 2, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0, 16'h0, 16'h0400);
        // 3.0*1.0 = 3.0
        set_vec(1, 1, 16'h0600, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0600);
        // -1.0*1.0 + 0.5*0.5 = -0.75
        set_vec(2, 2, 16'hFE00, 16'h0200, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'hFE80);
        // 1.0 + 2.0*0.5 + 0.25 = 2.25
        set_vec(3, 3, 16'h0200, 16'h0200, 16'h0400, 16'h0100, 16'h0100, 16'h0100, 16'h0480);
        // empty job
        set_vec(4, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000);
        // 1.5*-0.5 = -0.75
        set_vec(5, 1, 16'h0300, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFE80);

        cmd_valid = 1'b0;
        cmd_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        rst_n     = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_fmt", pe_format_en, 0);
        check("rst_data_a", pe_data_a, 0);
        check("rst_keep", pe_keep_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // ---- basic dot product with result latency ----
        exp_q.push_back(16'h0480);
        send_cmd(3);
        send_op(16'h0200, 16'h0200);
        send_op(16'h0400, 16'h0100);
        send_op(16'h0100, 16'h0100);
        @(negedge clk);
        check("fmt_pulse", pe_format_en, 1);
        check("last_op_a", pe_data_a, 16'h0100);
        check("busy_job", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("res_valid_lat", res_valid, (i == 3) ? 1 : 0);
            if (i == 1) check("fmt_single", pe_format_en, 0);
        end
        @(posedge clk); #1;
        wait_drain();

        // ---- table: back-to-back jobs, no gaps ----
        for (int v = 0; v < NV; v++) begin
            exp_q.push_back(vecs[v].exp_res);
            send_cmd(vecs[v].len);
            for (int j = 0; j < vecs[v].len; j++) send_op(vecs[v].a[j], vecs[v].b[j]);
        end
        wait_drain();

        // ---- zero length then a stalled job ----
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0500);
        send_cmd(0);
        send_cmd(2);
        send_op(16'h0400, 16'h0200);
        @(negedge clk);
        check("op_present", pe_data_a, 16'h0400);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) begin
                @(negedge clk);
                check("stall_zero_a", pe_data_a, 0);
                check("stall_zero_b", pe_data_b, 0);
            end
        end
        send_op(16'h0100, 16'h0200);
        wait_drain();

        // ---- backpressure: four credits, six jobs ----
        res_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(16'(k * 16'h0200));
            send_cmd(1);
            send_op(16'(k * 16'h0200), 16'h0200);
        end
        cmd_valid = 1'b1;
        cmd_len   = 8'd1;
        @(negedge clk);
        check("cmd_ready_full", cmd_ready, 0);
        repeat (6) @(negedge clk);
        check("bp_res_valid", res_valid, 1);
        check("bp_res_hold1", res_data, 16'h0200);
        check("bp_cmd_blocked", cmd_ready, 0);
        repeat (2) @(negedge clk);
        check("bp_res_hold2", res_data, 16'h0200);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("cmd_ready_before_drain", cmd_ready, 0);
        @(posedge clk); #1;
        for (int k = 5; k <= 6; k++) begin
            exp_q.push_back(16'(k * 16'h0200));
            send_cmd(1);
            send_op(16'(k * 16'h0200), 16'h0200);
        end
        wait_drain();
        check("idle_not_busy", busy, 0);

        // ---- asynchronous reset in the middle of a stream ----
        send_cmd(5);
        send_op(16'h0200, 16'h0200);
        send_op(16'h0400, 16'h0200);
        check("pre_reset_data", pe_data_a, 16'h0400);
        op_valid = 1'b1;
        op_a     = 16'h0300;
        op_b     = 16'h0200;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data_a", pe_data_a, 0);
        check("arst_data_b", pe_data_b, 0);
        check("arst_busy", busy, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_res_data", res_data, 0);
        check("arst_op_ready", op_ready, 0);
        check("arst_fmt", pe_format_en, 0);
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_res_valid", res_valid, 0);
        @(posedge clk); #1;
        exp_q.push_back(16'h0200);
        send_cmd(1);
        send_op(16'h0200, 16'h0200);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
